// File: rtl/game_ctrl_pkg.sv
// Shared state encodings and defaults for the game tick scheduler and its debug display.
package game_ctrl_pkg;
  localparam int STATE_W    = 3;
  localparam int GOAL_Y_DEF = 3360;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_WIN   = 3'd4
  } state_t;
endpackage

// File: rtl/game_tick_sched_if.sv
// Tick, video-timing, button and debug signals between fq_div, the scheduler and tb_character.
interface game_tick_sched_if #(
  parameter int PHY_WIDTH  = 16,
  parameter int SEQ_LEN    = 20,
  parameter int DROP_WIDTH = 8
);
  import game_ctrl_pkg::*;

  logic                          tick_in;
  logic                          vblank;
  logic                          start_btn;
  logic                          pause_btn;
  logic                          step_btn;
  logic signed [PHY_WIDTH:0]     char_pos_y;
  logic                          char_tick;
  logic [STATE_W-1:0]            state;
  logic [SEQ_LEN-1:0]            run_ticks;
  logic [DROP_WIDTH-1:0]         drop_cnt;
  logic                          game_restart;

  modport master (
    output tick_in, vblank, start_btn, pause_btn, step_btn, char_pos_y,
    input  char_tick, state, run_ticks, drop_cnt, game_restart
  );

  modport slave (
    input  tick_in, vblank, start_btn, pause_btn, step_btn, char_pos_y,
    output char_tick, state, run_ticks, drop_cnt, game_restart
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear, async active-low reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end
endmodule

// File: rtl/game_tick_sched.sv
// Gates fq_div ticks by game state and re-times granted ticks into vertical blanking.
module game_tick_sched
  import game_ctrl_pkg::*;
#(
  parameter int PHY_WIDTH  = 16,
  parameter int GOAL_Y     = GOAL_Y_DEF,
  parameter int SEQ_LEN    = 20,
  parameter int DROP_WIDTH = 8
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  game_tick_sched_if.slave bus
);
  localparam logic signed [PHY_WIDTH:0] GOAL_S = (PHY_WIDTH+1)'(GOAL_Y);

  state_t                st;
  logic                  pending;
  logic                  char_tick_q;
  logic                  game_restart_q;
  logic [SEQ_LEN-1:0]    run_ticks_q;
  logic [DROP_WIDTH-1:0] drop_q;
  logic                  at_goal;
  logic                  issue;
  logic                  overrun;

  assign at_goal = (bus.char_pos_y >= GOAL_S);

  // A pending tick is withheld on the cycle RUN hands over to WIN.
  always_comb begin
    issue   = 1'b0;
    overrun = 1'b0;
    if (bus.vblank && !char_tick_q) begin
      case (st)
        ST_RUN:  issue = pending && !at_goal;
        ST_STEP: issue = 1'b1;
        default: issue = 1'b0;
      endcase
    end
    overrun = (st == ST_RUN) && bus.tick_in && pending && !issue;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st             <= ST_IDLE;
      pending        <= 1'b0;
      char_tick_q    <= 1'b0;
      game_restart_q <= 1'b0;
      run_ticks_q    <= '0;
    end else begin
      char_tick_q    <= issue;
      game_restart_q <= 1'b0;
      if (char_tick_q) begin
        run_ticks_q <= run_ticks_q + SEQ_LEN'(1);
      end
      if (st == ST_RUN) begin
        pending <= (pending && !issue) || bus.tick_in;
      end else begin
        pending <= 1'b0;
      end
      case (st)
        ST_IDLE: begin
          if (bus.start_btn) st <= ST_RUN;
        end
        ST_RUN: begin
          if (at_goal)            st <= ST_WIN;
          else if (bus.pause_btn) st <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (bus.pause_btn)     st <= ST_RUN;
          else if (bus.step_btn) st <= ST_STEP;
        end
        ST_STEP: begin
          if (issue) st <= ST_PAUSE;
        end
        ST_WIN: begin
          if (bus.start_btn) begin
            st             <= ST_IDLE;
            game_restart_q <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(DROP_WIDTH)) u_drop_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .inc   (overrun),
    .clear (1'b0),
    .value (drop_q)
  );

  assign bus.char_tick    = char_tick_q;
  assign bus.state        = st;
  assign bus.run_ticks    = run_ticks_q;
  assign bus.drop_cnt     = drop_q;
  assign bus.game_restart = game_restart_q;
endmodule
